mac_cyv_dot_seq: RTL and testbench

MAC_CYV_DOT_SEQ -- requirements
Module: mac_cyv_dot_seq

---
 rtl/mac_cyv_dot_seq.sv | 150 +++++++++++++++
 tb/tb_mac_cyv_dot_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_cyv_dot_seq.sv
// Purpose : fp16 dot-product sequencer; streams element pairs into an external
//           half-precision MAC one at a time and accumulates through its result.
// Latency : MAC_LAT+2 cycles per element; res_valid one cycle after the last capture.
// Backpr. : in_ready is high only in ISSUE; one element in flight, start ignored while busy.
//
// Ports:
//   clk, areset        rising-edge clock, synchronous active-high reset
//   start, len         begin a dot product of len element pairs (sampled in IDLE)
//   in_valid/in_ready  element pair handshake carrying in_a, in_b
//   mac_a/b/c, mac_q   registered operands to, and result from, the external MAC
//   init_c             accumulator seed, present only with MAC_CYV_SEQ_ACCINIT_EN
//   busy, res_valid    not-idle flag, one-cycle result strobe
//   res                dot-product result, held until the next result
//
// Optional feature macro: MAC_CYV_SEQ_ACCINIT_EN (adds init_c).

module mac_cyv_dot_seq #(
   parameter int MAC_LAT = 4,
   parameter int LEN_W   = 8
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   output logic [15:0]      mac_a,
   output logic [15:0]      mac_b,
   output logic [15:0]      mac_c,
   input  logic [15:0]      mac_q,
`ifdef MAC_CYV_SEQ_ACCINIT_EN
   input  logic [15:0]      init_c,
`endif
   output logic             busy,
   output logic             res_valid,
   output logic [15:0]      res
);

   localparam int WCNT_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            r_state;
   logic [LEN_W-1:0]  r_rem;
   logic [15:0]       r_acc;
   logic [WCNT_W-1:0] r_wcnt;
   logic [15:0]       r_mac_a;
   logic [15:0]       r_mac_b;
   logic [15:0]       r_mac_c;
   logic [15:0]       r_res;
   logic              r_res_valid;
   logic              r_in_ready;
   logic              r_busy;
   logic [15:0]       w_acc_init;

`ifdef MAC_CYV_SEQ_ACCINIT_EN
   assign w_acc_init = init_c;
`else
   assign w_acc_init = 16'h0000;
`endif

   always_ff @(posedge clk) begin
      if (areset) begin
         r_state     <= IDLE;
         r_rem       <= '0;
         r_acc       <= 16'h0000;
         r_wcnt      <= '0;
         r_mac_a     <= 16'h0000;
         r_mac_b     <= 16'h0000;
         r_mac_c     <= 16'h0000;
         r_res       <= 16'h0000;
         r_res_valid <= 1'b0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_acc  <= w_acc_init;
                  r_busy <= 1'b1;
                  if (len != '0) begin
                     r_rem      <= len;
                     r_in_ready <= 1'b1;
                     r_state    <= ISSUE;
                  end else begin
                     // Empty vector: result is the seed itself, strobed in DONE.
                     r_res       <= w_acc_init;
                     r_res_valid <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            ISSUE: begin
               if (in_valid) begin
                  r_mac_a    <= in_a;
                  r_mac_b    <= in_b;
                  r_mac_c    <= r_acc;
                  r_wcnt     <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= WAIT;
               end
            end
            WAIT: begin
               // Operands sit at the MAC for MAC_LAT cycles after the issue
               // cycle; mac_q is valid in the (MAC_LAT+1)th WAIT cycle.
               if (r_wcnt == WCNT_W'(MAC_LAT)) begin
                  r_acc  <= mac_q;
                  r_rem  <= r_rem - LEN_W'(1);
                  r_wcnt <= '0;
                  if (r_rem == LEN_W'(1)) begin
                     // Load res on DONE entry so it is valid alongside the strobe.
                     r_res       <= mac_q;
                     r_res_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_in_ready <= 1'b1;
                     r_state    <= ISSUE;
                  end
               end else begin
                  r_wcnt <= r_wcnt + WCNT_W'(1);
               end
            end
            DONE: begin
               r_res_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign mac_a     = r_mac_a;
   assign mac_b     = r_mac_b;
   assign mac_c     = r_mac_c;
   assign busy      = r_busy;
   assign res_valid = r_res_valid;
   assign res       = r_res;

endmodule

// File: tb/tb_mac_cyv_dot_seq.sv
// Purpose : directed bench for mac_cyv_dot_seq paired with a MAC_LAT=4 fp16 MAC model.
// Latency : expects one element per MAC_LAT+2 cycles, result strobe after the last capture.
// Backpr. : drives in_valid held high or stalled; checks in_ready windows and timing.

module tb_mac_cyv_dot_seq;

   localparam int MAC_LAT = 4;
   localparam int LEN_W   = 8;

   logic             clk = 1'b0;
   logic             areset;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_a, in_b;
   logic [15:0]      mac_a, mac_b, mac_c;
   logic [15:0]      mac_q;
   logic             busy, res_valid;
   logic [15:0]      res;
`ifdef MAC_CYV_SEQ_ACCINIT_EN
   logic [15:0]      init_c;
`endif

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   mac_cyv_dot_seq #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .areset    (areset),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mac_a     (mac_a),
      .mac_b     (mac_b),
      .mac_c     (mac_c),
      .mac_q     (mac_q),
`ifdef MAC_CYV_SEQ_ACCINIT_EN
      .init_c    (init_c),
`endif
      .busy      (busy),
      .res_valid (res_valid),
      .res       (res)
   );

   // fp16 a*b+c for the operand triples this bench uses; anything else is NaN.
   function automatic logic [15:0] fma_lut(input logic [15:0] a, b, c);
      case ({a, b, c})
         {16'h4000, 16'h4200, 16'h0000}: return 16'h4600; // 2*3+0 = 6
         {16'h3C00, 16'h4000, 16'h0000}: return 16'h4000; // 1*2+0 = 2
         {16'h4000, 16'h4200, 16'h4000}: return 16'h4800; // 2*3+2 = 8
         {16'h4000, 16'h4200, 16'h3C00}: return 16'h4700; // 2*3+1 = 7
         {16'h3C00, 16'h3C00, 16'h0000}: return 16'h3C00; // 1*1+0 = 1
         default:                        return 16'h7E00;
      endcase
   endfunction

   // MAC model: operands registered at the MAC produce mac_q MAC_LAT cycles later.
   logic [15:0] pipe [MAC_LAT];
   always @(posedge clk) begin
      pipe[0] <= fma_lut(mac_a, mac_b, mac_c);
      for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mac_q = pipe[MAC_LAT-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      int          n;
      logic [15:0] a0, b0, a1, b1;
      logic [15:0] c1;      // expected mac_c on the second issue
      logic [15:0] exp_res;
   } vec_t;

   // Start a dot product with in_valid held high and check issue timing and result.
   task automatic run_vec(input vec_t v, input logic [15:0] init);
      int          idx, pulses, res_cyc;
      int          xf [2];
      logic [15:0] res_cap;
      logic        xfer;
      idx = 0; pulses = 0; res_cyc = -1; res_cap = 16'h0000;
      xf[0] = -100; xf[1] = -100;
      start = 1'b1; len = LEN_W'(v.n); in_valid = 1'b1; in_a = v.a0; in_b = v.b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (res_valid) begin pulses++; res_cap = res; res_cyc = k; end
         if (idx > 0 && k == xf[idx-1] + 1) begin
            chk("issue mac_a", mac_a, (idx == 1) ? v.a0 : v.a1);
            chk("issue mac_b", mac_b, (idx == 1) ? v.b0 : v.b1);
            chk("issue mac_c", mac_c, (idx == 1) ? init : v.c1);
         end
         xfer = in_ready && in_valid && (idx < v.n);
         if (xfer) begin xf[idx] = k; idx++; end
         @(posedge clk); #1;
         start = 1'b0;
         if (xfer) begin
            if (idx == 1 && v.n == 2) begin in_a = v.a1; in_b = v.b1; end
            else in_valid = 1'b0;
         end
      end
      chk("transfers", idx, v.n);
      chk("res_valid pulses", pulses, 1);
      chk("res value", res_cap, v.exp_res);
      chk("result delay", res_cyc - xf[v.n-1], MAC_LAT + 2);
      if (v.n == 2) chk("issue interval", xf[1] - xf[0], MAC_LAT + 2);
   endtask

   vec_t tbl [3];

   initial begin
      int          n, pulses;
      logic [15:0] r;

      tbl[0] = '{n: 1, a0: 16'h4000, b0: 16'h4200, a1: 16'h0000, b1: 16'h0000,
                 c1: 16'h0000, exp_res: 16'h4600};
      tbl[1] = '{n: 2, a0: 16'h3C00, b0: 16'h4000, a1: 16'h4000, b1: 16'h4200,
                 c1: 16'h4000, exp_res: 16'h4800};
      tbl[2] = '{n: 1, a0: 16'h3C00, b0: 16'h3C00, a1: 16'h0000, b1: 16'h0000,
                 c1: 16'h0000, exp_res: 16'h3C00};

      areset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0;
`ifdef MAC_CYV_SEQ_ACCINIT_EN
      init_c = 16'h0000;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", busy, 0);
      chk("rst in_ready", in_ready, 0);
      chk("rst res_valid", res_valid, 0);
      chk("rst res", res, 16'h0000);
      chk("rst mac_a", mac_a, 16'h0000);
      chk("rst mac_b", mac_b, 16'h0000);
      chk("rst mac_c", mac_c, 16'h0000);
      areset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 3; i++) begin
         run_vec(tbl[i], 16'h0000);
         repeat (2) @(posedge clk);
         #1;
      end

      // len=0: immediate result, no transfer, in_ready stays low.
      start = 1'b1; len = '0; in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222;
      @(negedge clk);
      chk("len0 in_ready idle", in_ready, 0);
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      chk("len0 res_valid", res_valid, 1);
      chk("len0 res", res, 16'h0000);
      chk("len0 in_ready", in_ready, 0);
      chk("len0 busy", busy, 1);
      @(negedge clk);
      chk("len0 res_valid drop", res_valid, 0);
      chk("len0 busy drop", busy, 0);
      chk("len0 in_ready after", in_ready, 0);
      chk("len0 mac_a held", mac_a, tbl[2].a0);
      @(posedge clk); #1; in_valid = 1'b0;

      // Stall: in_valid low for 3 ISSUE cycles, then a late transfer.
      start = 1'b1; len = LEN_W'(1);
      @(posedge clk); #1; start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall in_ready", in_ready, 1);
         chk("stall mac_a", mac_a, tbl[2].a0);
         chk("stall mac_b", mac_b, tbl[2].b0);
         @(posedge clk); #1;
      end
      in_valid = 1'b1; in_a = 16'h4000; in_b = 16'h4200;
      @(negedge clk);
      chk("stall xfer ready", in_ready, 1);
      @(posedge clk); #1; in_valid = 1'b0;
      n = -1; r = 16'h0;
      for (int k = 1; k < 20 && n < 0; k++) begin
         @(negedge clk);
         if (res_valid) begin n = k; r = res; end
      end
      chk("stall result delay", n, MAC_LAT + 2);
      chk("stall res", r, 16'h4600);
      repeat (2) @(posedge clk);
      #1;

      // Reset in WAIT discards the in-flight element.
      start = 1'b1; len = LEN_W'(1); in_valid = 1'b1; in_a = 16'h4000; in_b = 16'h4200;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre-reset busy", busy, 1);
      areset = 1'b1;
      @(posedge clk); #1; areset = 1'b0;
      @(negedge clk);
      chk("rst-wait busy", busy, 0);
      chk("rst-wait in_ready", in_ready, 0);
      chk("rst-wait res", res, 16'h0000);
      chk("rst-wait mac_a", mac_a, 16'h0000);
      chk("rst-wait mac_c", mac_c, 16'h0000);
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (res_valid || busy) pulses++;
      end
      chk("rst-wait quiet", pulses, 0);

      // Reset wins over start in the same cycle.
      @(posedge clk); #1;
      areset = 1'b1; start = 1'b1; len = LEN_W'(1);
      @(posedge clk); #1; areset = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst prio busy", busy, 0);
      chk("rst prio in_ready", in_ready, 0);

`ifdef MAC_CYV_SEQ_ACCINIT_EN
      @(posedge clk); #1;
      init_c = 16'h3C00;
      run_vec('{n: 1, a0: 16'h4000, b0: 16'h4200, a1: 16'h0000, b1: 16'h0000,
                c1: 16'h0000, exp_res: 16'h4700}, 16'h3C00);
      start = 1'b1; len = '0;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      chk("init len0 res_valid", res_valid, 1);
      chk("init len0 res", res, 16'h3C00);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
